// File: rtl/alu_logical.sv
// alu_logical: logic and shift slice of the integer ALU.
//   Bitwise AND/OR/XOR/NOR, logical left shift and logical/arithmetic right
//   shift of in1 by in2[log2(WIDTH)-1:0], selected by {sel2,sel1,sel0}.
//   Every result, including the intermediates, is registered (1-cycle latency).
// Ports:
//   clk, reset       - rising-edge clock, synchronous active-high reset
//   in1, in2         - operands; in1 is the shifted value, in2 low bits = amount
//   sel0/sel1/sel2   - op select (sel2: 0 = logical group, 1 = shift group)
//   out              - final registered result
//   logical_32_out   - registered logical-unit result
//   sll_out          - registered shift-left-logical result
//   srl_sra_out      - registered right-shift result (sel0: 1 = SRL, 0 = SRA)
//   mux_0_out        - registered shift-group mux result
//   zero             - only with ALU_LOGICAL_ZERO_FLAG_EN: 1 iff out is all zeros
// Optional feature macro: ALU_LOGICAL_ZERO_FLAG_EN
module alu_logical #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             sel0,
  input  logic             sel1,
  input  logic             sel2,
`ifdef ALU_LOGICAL_ZERO_FLAG_EN
  output logic             zero,
`endif
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] logical_32_out,
  output logic [WIDTH-1:0] sll_out,
  output logic [WIDTH-1:0] srl_sra_out,
  output logic [WIDTH-1:0] mux_0_out
);

  localparam int unsigned SHW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic [SHW-1:0]   shamt;
  logic [WIDTH-1:0] logical_32_d, logical_32_q;
  logic [WIDTH-1:0] sll_d,        sll_q;
  logic [WIDTH-1:0] srl_sra_d,    srl_sra_q;
  logic [WIDTH-1:0] mux_0_d,      mux_0_q;
  logic [WIDTH-1:0] out_d,        out_q;

  assign shamt = in2[SHW-1:0];

  always_comb begin
    logical_32_d = '0;
    unique case ({sel1, sel0})
      2'b00:   logical_32_d = in1 & in2;
      2'b01:   logical_32_d = in1 | in2;
      2'b10:   logical_32_d = in1 ^ in2;
      default: logical_32_d = ~(in1 | in2);
    endcase

    sll_d = in1 << shamt;

    // Arithmetic shift works on the signed view of in1 so the sign bit fills.
    if (sel0) srl_sra_d = in1 >> shamt;
    else      srl_sra_d = $unsigned($signed(in1) >>> shamt);

    mux_0_d = sel1 ? sll_d : srl_sra_d;
    out_d   = sel2 ? mux_0_d : logical_32_d;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      logical_32_q <= '0;
      sll_q        <= '0;
      srl_sra_q    <= '0;
      mux_0_q      <= '0;
      out_q        <= '0;
    end else begin
      logical_32_q <= logical_32_d;
      sll_q        <= sll_d;
      srl_sra_q    <= srl_sra_d;
      mux_0_q      <= mux_0_d;
      out_q        <= out_d;
    end
  end

  assign logical_32_out = logical_32_q;
  assign sll_out        = sll_q;
  assign srl_sra_out    = srl_sra_q;
  assign mux_0_out      = mux_0_q;
  assign out            = out_q;

`ifdef ALU_LOGICAL_ZERO_FLAG_EN
  logic zero_d, zero_q;

  assign zero_d = (out_d == '0);

  always_ff @(posedge clk) begin
    if (reset) zero_q <= 1'b0;
    else       zero_q <= zero_d;
  end

  assign zero = zero_q;
`endif

endmodule

// File: tb/tb_alu_logical.sv
// Scoreboard bench for alu_logical: stimulus pushes the model's expected
// register contents; a monitor pops and compares one entry per clock.
module tb_alu_logical;

  logic        clk;
  logic        reset;
  logic [31:0] in1, in2;
  logic        sel0, sel1, sel2;
  logic [31:0] out, logical_32_out, sll_out, srl_sra_out, mux_0_out;
`ifdef ALU_LOGICAL_ZERO_FLAG_EN
  logic        zero;
`endif

  alu_logical #(.WIDTH(32)) dut (
    .clk            (clk),
    .reset          (reset),
    .in1            (in1),
    .in2            (in2),
    .sel0           (sel0),
    .sel1           (sel1),
    .sel2           (sel2),
`ifdef ALU_LOGICAL_ZERO_FLAG_EN
    .zero           (zero),
`endif
    .out            (out),
    .logical_32_out (logical_32_out),
    .sll_out        (sll_out),
    .srl_sra_out    (srl_sra_out),
    .mux_0_out      (mux_0_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] out;
    logic [31:0] logical;
    logic [31:0] sll;
    logic [31:0] srl_sra;
    logic [31:0] mux0;
    logic        zero;
  } exp_t;

  exp_t exp_q[$];
  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  // Reference model: per-bit description of each shift, op table for the rest.
  function automatic exp_t model(input logic rst, input logic [31:0] a,
                                 input logic [31:0] b, input logic [2:0] op);
    exp_t e;
    int amt;
    logic [31:0] sll, srl, sra, lg;
    amt = int'(b % 32);
    for (int i = 0; i < 32; i++) begin
      sll[i] = (i >= amt) ? a[i - amt] : 1'b0;
      srl[i] = (i + amt <= 31) ? a[i + amt] : 1'b0;
      sra[i] = (i + amt <= 31) ? a[i + amt] : a[31];
    end
    case (op[1:0])
      2'd0: lg = a & b;
      2'd1: lg = a | b;
      2'd2: lg = a ^ b;
      default: lg = ~(a | b);
    endcase
    e.logical = lg;
    e.sll     = sll;
    e.srl_sra = op[0] ? srl : sra;
    e.mux0    = op[1] ? sll : e.srl_sra;
    e.out     = op[2] ? e.mux0 : lg;
    e.zero    = (e.out == 32'h0);
    if (rst) begin
      e.out = '0; e.logical = '0; e.sll = '0; e.srl_sra = '0; e.mux0 = '0;
      e.zero = 1'b0;
    end
    return e;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
  endtask

  // Drive one op (right after a falling edge) and record the expectation.
  task automatic apply(input logic rst, input logic [31:0] a, input logic [31:0] b,
                       input logic [2:0] op);
    reset = rst; in1 = a; in2 = b;
    {sel2, sel1, sel0} = op;
    exp_q.push_back(model(rst, a, b, op));
    @(negedge clk);
  endtask

  // Monitor: registers update on every rising edge, so one entry per cycle.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("out",            out,            e.out);
        chk("logical_32_out", logical_32_out, e.logical);
        chk("sll_out",        sll_out,        e.sll);
        chk("srl_sra_out",    srl_sra_out,    e.srl_sra);
        chk("mux_0_out",      mux_0_out,      e.mux0);
`ifdef ALU_LOGICAL_ZERO_FLAG_EN
        chk("zero",           {31'b0, zero},  {31'b0, e.zero});
`endif
      end
    end
  end

  initial begin
    int unsigned wait_cycles;
    // Reset with NOR-of-ones presented, then release.
    apply(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011);
    apply(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 3'b011);
    // Logical group, back-to-back.
    apply(1'b0, 32'h0000_000F, 32'h0000_0005, 3'b000);
    apply(1'b0, 32'h0000_000F, 32'h0000_0005, 3'b001);
    apply(1'b0, 32'h0000_000F, 32'h0000_0005, 3'b010);
    apply(1'b0, 32'h0000_000F, 32'h0000_0005, 3'b011);
    // Shifts.
    apply(1'b0, 32'h0000_0030, 32'h0000_0004, 3'b110);
    apply(1'b0, 32'h0000_0030, 32'h0000_0004, 3'b111);
    apply(1'b0, 32'h8000_0010, 32'h0000_0004, 3'b100);
    apply(1'b0, 32'h8000_0010, 32'h0000_0004, 3'b101);
    // Boundaries: amount 0 via upper in2 bits, amount 31.
    apply(1'b0, 32'hDEAD_BEEF, 32'h0000_0020, 3'b110);
    apply(1'b0, 32'hDEAD_BEEF, 32'hFFFF_FFE0, 3'b100);
    apply(1'b0, 32'hDEAD_BEEF, 32'h0000_0020, 3'b101);
    apply(1'b0, 32'h8000_0000, 32'd31,        3'b100);
    apply(1'b0, 32'h8000_0000, 32'd31,        3'b101);
    apply(1'b0, 32'h0000_0001, 32'd31,        3'b110);
    // Zero result from XOR of equal operands.
    apply(1'b0, 32'h1234_5678, 32'h1234_5678, 3'b010);
    // Reset mid-stream with a non-zero op presented.
    apply(1'b0, 32'hA5A5_A5A5, 32'h0000_0003, 3'b110);
    apply(1'b1, 32'hA5A5_A5A5, 32'h0000_0003, 3'b110);
    apply(1'b0, 32'hA5A5_A5A5, 32'h0000_0003, 3'b101);
    // Random stream with occasional reset.
    for (int i = 0; i < 300; i++)
      apply(($urandom_range(0, 29) == 0), $urandom, $urandom, 3'($urandom_range(0, 7)));
    // Drain scoreboard with a bounded wait.
    wait_cycles = 0;
    while (exp_q.size() > 0 && wait_cycles < 10) begin
      @(negedge clk);
      wait_cycles++;
    end
    if (exp_q.size() > 0) begin
      n_total++;
      $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
    end
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
